// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode seven-segment display.
// Shadow registers take writes at any time; the displayed copy only updates at frame ends or while off.
module seg7_scan_ctrl #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_en,
  input  logic [2:0]        wr_idx,
  input  logic [4:0]        wr_val,
  input  logic              lz_blank_en,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an,
  output logic              frame_tick
);

  localparam int unsigned IW          = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW          = $clog2(CLK_DIV);
  localparam int unsigned SHOW_CYCLES = CLK_DIV - BLANK_CYCLES;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DIGITS-1:0][4:0]  shadow_q, shadow_d;
  logic [DIGITS-1:0][4:0]  display_q, display_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [DIGITS-1:0]       an_q, an_d;
  logic                    frame_tick_q, frame_tick_d;
  logic [DIGITS-1:0]       lz_c;
  logic                    copy_c;

  function automatic logic [6:0] decode7(input logic [3:0] code);
    case (code)
      4'd0:    decode7 = 7'b0111111;
      4'd1:    decode7 = 7'b0000110;
      4'd2:    decode7 = 7'b1011011;
      4'd3:    decode7 = 7'b1001111;
      4'd4:    decode7 = 7'b1100110;
      4'd5:    decode7 = 7'b1101101;
      4'd6:    decode7 = 7'b1111101;
      4'd7:    decode7 = 7'b0000111;
      4'd8:    decode7 = 7'b1111111;
      4'd9:    decode7 = 7'b1100111;
      4'd10:   decode7 = 7'b1000000;
      default: decode7 = 7'b0000000;
    endcase
  endfunction

  // Scan sequencing: dropping en always restarts from digit 0 after a fresh guard interval.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = ST_OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == CW'(SHOW_CYCLES - 1)) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Same-cycle writes are folded into the copy so they are never lost at a frame boundary.
  always_comb begin
    shadow_d = shadow_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (wr_en && (wr_idx == 3'(i))) begin
        shadow_d[IW'(i)] = wr_val;
      end
    end
    copy_c    = (state_q == ST_OFF) || frame_tick_q;
    display_d = copy_c ? shadow_d : display_q;
  end

  // A digit is a leading zero when it and every digit above it hold code 0.
  always_comb begin
    logic zero_above;
    logic code_zero;
    zero_above = 1'b1;
    code_zero  = 1'b0;
    lz_c       = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      code_zero       = (display_q[IW'(i)][3:0] == 4'd0);
      lz_c[IW'(i)]    = zero_above && code_zero && (i != 0);
      zero_above      = zero_above && code_zero;
    end
  end

  always_comb begin
    seg_d        = '0;
    dp_d         = 1'b0;
    an_d         = '0;
    frame_tick_d = (state_d == ST_SHOW) && (idx_d == IW'(DIGITS - 1)) &&
                   (cnt_d == CW'(SHOW_CYCLES - 1));
    if (state_d == ST_SHOW) begin
      an_d[idx_d] = 1'b1;
      dp_d        = display_q[idx_d][4];
      seg_d       = (lz_blank_en && lz_c[idx_d]) ? 7'b0000000 : decode7(display_q[idx_d][3:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_OFF;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      display_q    <= '0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      an_q         <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: frame-position reference model, vector table, hand-written corner sequences.
module tb_seg7_scan_ctrl;

  localparam int D  = 4;
  localparam int CD = 8;
  localparam int B  = 2;
  localparam int FL = D * CD;

  logic       clk, rst, en, wr_en, lz_blank_en;
  logic [2:0] wr_idx;
  logic [4:0] wr_val;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;

  int tests = 0;
  int fails = 0;

  seg7_scan_ctrl #(.DIGITS(D), .CLK_DIV(CD), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_idx(wr_idx), .wr_val(wr_val),
    .lz_blank_en(lz_blank_en), .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: scanning is a position within a D*CLK_DIV-cycle frame.
  bit         m_on;
  int         m_pos;
  logic [4:0] m_sh [D];
  logic [4:0] m_disp [D];
  logic [6:0] e_seg;
  logic       e_dp;
  logic [3:0] e_an;
  logic       e_ft;
  logic [6:0] seg_tbl [16];

  initial begin
    seg_tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 7'b1101101,
                7'b1111101, 7'b0000111, 7'b1111111, 7'b1100111, 7'b1000000, 7'b0000000,
                7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
  end

  task automatic model_reset();
    m_on = 0; m_pos = 0;
    for (int i = 0; i < D; i++) begin m_sh[i] = '0; m_disp[i] = '0; end
    e_seg = '0; e_dp = 0; e_an = '0; e_ft = 0;
  endtask

  task automatic model_edge();
    bit copy;
    int slot;
    bit blank;
    copy = !m_on || (m_pos == FL - 1);
    if (wr_en && int'(wr_idx) < D) m_sh[wr_idx] = wr_val;
    if (copy) for (int i = 0; i < D; i++) m_disp[i] = m_sh[i];
    if (!en) begin m_on = 0; m_pos = 0; end
    else if (!m_on) begin m_on = 1; m_pos = 0; end
    else m_pos = (m_pos + 1) % FL;
    e_seg = '0; e_dp = 0; e_an = '0;
    e_ft = m_on && (m_pos == FL - 1);
    if (m_on && (m_pos % CD) >= B) begin
      slot = m_pos / CD;
      e_an = 4'(1 << slot);
      e_dp = m_disp[slot][4];
      blank = lz_blank_en && (slot != 0);
      for (int j = slot; j < D; j++) if (m_disp[j][3:0] != 4'd0) blank = 0;
      e_seg = blank ? 7'b0 : seg_tbl[m_disp[slot][3:0]];
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    @(negedge clk);
    cmp("cycle {ft,an,dp,seg}", {19'b0, frame_tick, an, dp, seg}, {19'b0, e_ft, e_an, e_dp, e_seg});
  endtask

  task automatic wait_an(input logic [3:0] target, input string nm);
    int n = 0;
    while (an !== target && n < 100) begin step(); n++; end
    cmp(nm, {28'b0, an}, {28'b0, target});
  endtask

  typedef struct {
    logic [19:0] vals;
    bit          lz;
    logic [27:0] exp_seg;
    logic [3:0]  exp_dp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int first_lit, t1, t2, nticks;
    logic [3:0] an_hist [80];
    logic [6:0] seen_seg [D];
    logic       seen_dp [D];
    logic [3:0] seen;
    logic [19:0] vv;
    logic [27:0] es;
    logic [3:0]  ed;

    vecs[0] = '{{5'd3, 5'd2, 5'd1, 5'd0}, 1'b0,
                {7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111}, 4'b0000};
    vecs[1] = '{{5'd0, 5'd0, 5'd5, 5'd0}, 1'b1,
                {7'b0000000, 7'b0000000, 7'b1101101, 7'b0111111}, 4'b0000};
    vecs[2] = '{{5'd0, 5'd0, 5'd0, 5'd0}, 1'b1,
                {7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111}, 4'b0000};
    vecs[3] = '{{5'd7, 5'd8, 5'b11100, 5'b11010}, 1'b0,
                {7'b0000111, 7'b1111111, 7'b0000000, 7'b1000000}, 4'b0011};
    vecs[4] = '{{5'd9, 5'd6, 5'd4, 5'd0}, 1'b1,
                {7'b1100111, 7'b1111101, 7'b1100110, 7'b0111111}, 4'b0000};

    rst = 1; en = 0; wr_en = 0; wr_idx = '0; wr_val = '0; lz_blank_en = 0;
    model_reset();
    step(); step();
    cmp("reset outputs", {19'b0, frame_tick, an, dp, seg}, 32'd0);

    // Release from reset with scanning enabled
    rst = 0; en = 1;
    first_lit = -1; t1 = -1; t2 = -1; nticks = 0;
    for (int c = 1; c <= 70; c++) begin
      step();
      if (c < 80) an_hist[c] = an;
      if (an != 0 && first_lit < 0) first_lit = c;
      if (frame_tick) begin
        nticks++;
        if (t1 < 0) t1 = c; else if (t2 < 0) t2 = c;
      end
    end
    cmp("first lit cycle", first_lit, 3);
    cmp("digit0 last lit", {28'b0, an_hist[8]}, 32'b0001);
    cmp("guard after digit0", {28'b0, an_hist[9] | an_hist[10]}, 32'b0);
    cmp("digit1 first lit", {28'b0, an_hist[11]}, 32'b0010);
    cmp("tick count", nticks, 2);
    cmp("first tick cycle", t1, 32);
    cmp("tick period", t2 - t1, 32);

    // Vector table: load all digits while off, then observe one frame
    for (int v = 0; v < 5; v++) begin
      vv = vecs[v].vals; es = vecs[v].exp_seg; ed = vecs[v].exp_dp;
      en = 0; lz_blank_en = vecs[v].lz;
      step();
      for (int k = 0; k < D; k++) begin
        wr_en = 1; wr_idx = 3'(k); wr_val = vv[k*5 +: 5];
        step();
      end
      wr_en = 0;
      step();
      en = 1; seen = '0;
      for (int c = 0; c < FL + 4; c++) begin
        step();
        for (int k = 0; k < D; k++)
          if (an == 4'(1 << k)) begin seen[k] = 1; seen_seg[k] = seg; seen_dp[k] = dp; end
      end
      for (int k = 0; k < D; k++) begin
        cmp($sformatf("vec%0d digit%0d seg", v, k), {24'b0, seen[k], seen_seg[k]},
            {24'b0, 1'b1, es[k*7 +: 7]});
        cmp($sformatf("vec%0d digit%0d dp", v, k), {31'b0, seen_dp[k]}, {31'b0, ed[k]});
      end
    end

    // Mid-frame write of digit0 while digit2 is lit; visible only from next frame
    wait_an(4'b0100, "wait digit2");
    wr_en = 1; wr_idx = 3'd0; wr_val = 5'd9;
    step();
    wr_en = 0;
    begin
      int n = 0;
      while (!frame_tick && n < 100) begin step(); n++; end
      cmp("frame tick after write", {31'b0, frame_tick}, 32'd1);
    end
    wait_an(4'b0001, "wait digit0 next frame");
    cmp("digit0 new value", {25'b0, seg}, {25'b0, 7'b1100111});

    // Write to the lit digit: the rest of its slot keeps the old value
    wr_en = 1; wr_idx = 3'd0; wr_val = 5'd3;
    step();
    wr_en = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      cmp("digit0 held old", {25'b0, seg}, {25'b0, 7'b1100111});
    end

    // Out-of-range indices leave every register alone
    for (int k = 4; k < 8; k++) begin
      wr_en = 1; wr_idx = 3'(k); wr_val = 5'h1f;
      step();
    end
    wr_en = 0;
    for (int c = 0; c < 2 * FL; c++) step();

    // en dropped while digit2 lit, then re-enabled
    wait_an(4'b0100, "wait digit2 for en drop");
    en = 0;
    step();
    cmp("en drop an", {28'b0, an}, 32'd0);
    step();
    en = 1;
    step(); cmp("re-enable guard 1", {28'b0, an}, 32'd0);
    step(); cmp("re-enable guard 2", {28'b0, an}, 32'd0);
    step(); cmp("re-enable digit0", {28'b0, an}, 32'b0001);

    // Asynchronous reset mid-SHOW
    wait_an(4'b0010, "wait digit1 for rst");
    #2 rst = 1;
    #1 cmp("async rst outputs", {19'b0, frame_tick, an, dp, seg}, 32'd0);
    model_reset();
    step();
    rst = 0; en = 1; lz_blank_en = 0;
    wait_an(4'b0001, "restart digit0");
    cmp("restart digit0 seg", {25'b0, seg}, {25'b0, 7'b0111111});
    wait_an(4'b1000, "restart digit3");
    cmp("restart digit3 seg", {25'b0, seg}, {25'b0, 7'b0111111});

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      en          = ($urandom_range(0, 99) != 0);
      wr_en       = ($urandom_range(0, 9) < 3);
      wr_idx      = 3'($urandom_range(0, 7));
      wr_val      = 5'($urandom);
      lz_blank_en = ($urandom_range(0, 15) != 0) ? lz_blank_en : ~lz_blank_en;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
